// File: rtl/norm_round.sv
// norm_round: sequential normalise-and-round stage of the single-precision
// FPU datapath. Accepts the raw sign / exponent / double-width mantissa from
// the multiply/add core, normalises the mantissa one bit per cycle, applies
// round-to-nearest-even and presents the packed fields to the result-packing
// stage.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   upstream operand valid
//   in_ready   stage can accept (IDLE only, low while in reset)
//   in_s       operand sign
//   in_e       biased exponent, two's complement, EXP_W+2 bits
//   in_m       unnormalised mantissa, binary point between bits 46 and 45
//   in_flag    class: 00 infinity, 01 invalid, 10 zero, 11 finite
//   out_valid  s/e/m/flag/oom valid
//   out_ready  downstream accepts
//   s, e, m    sign, biased exponent, fraction
//   flag       class for the packing stage
//   oom        exponent out of range (overflow or underflow)
module norm_round #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_s,
  input  logic [EXP_W+1:0]     in_e,
  input  logic [2*MAN_W+1:0]   in_m,
  input  logic [1:0]           in_flag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 s,
  output logic [EXP_W-1:0]     e,
  output logic [MAN_W-1:0]     m,
  output logic [1:0]           flag,
  output logic                 oom
);

  localparam int MW = 2 * MAN_W + 2;  // mantissa width
  localparam int XW = EXP_W + 2;      // internal signed exponent width

  localparam logic signed [XW-1:0] EXP_ONE = XW'(1);
  localparam logic signed [XW-1:0] EXP_MAX = XW'((2 ** EXP_W) - 2);

  localparam logic [1:0] FLAG_ZERO   = 2'b10;
  localparam logic [1:0] FLAG_FINITE = 2'b11;

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t                 state;
  logic [MW-1:0]          mant;
  logic signed [XW-1:0]   exp_q;
  logic                   sticky;
  logic                   sign_q;

  // Rounding datapath, only consumed in ROUND.
  logic                   round_inc;
  logic [MAN_W:0]         frac_sum;   // {carry, fraction} of the visible bits
  logic signed [XW-1:0]   exp_rnd;
  logic                   out_of_range;

  // NOTE: in_ready is gated with the raw reset pin so it is low for the
  // whole time reset is held, not just from the first clock edge after it.
  assign in_ready = rst && (state == IDLE);

  // NOTE: every signal written in this block gets a default first, so no
  // path through it can infer a latch.
  always_comb begin
    round_inc    = 1'b0;
    frac_sum     = '0;
    exp_rnd      = exp_q;
    out_of_range = 1'b0;

    // Hidden bit is implicit: adding to the 23 visible bits with one bit of
    // headroom; a carry out means the 1.111..1 + ulp case, i.e. 10.000..0.
    round_inc    = mant[MAN_W-1] & ((|mant[MAN_W-2:0]) | sticky | mant[MAN_W]);
    frac_sum     = {1'b0, mant[MW-3:MAN_W]} + {{MAN_W{1'b0}}, round_inc};
    exp_rnd      = frac_sum[MAN_W] ? (exp_q + EXP_ONE) : exp_q;
    out_of_range = (exp_rnd > EXP_MAX) || (exp_rnd < EXP_ONE);
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mant      <= '0;
      exp_q     <= '0;
      sticky    <= 1'b0;
      sign_q    <= 1'b0;
      out_valid <= 1'b0;
      s         <= 1'b0;
      e         <= '0;
      m         <= '0;
      flag      <= 2'b00;
      oom       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mant   <= in_m;
            exp_q  <= $signed(in_e);
            sticky <= 1'b0;
            sign_q <= in_s;
            if (in_flag != FLAG_FINITE) begin
              s         <= in_s;
              e         <= '0;
              m         <= '0;
              flag      <= in_flag;
              oom       <= 1'b0;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= NORM;
            end
          end
        end

        NORM: begin
          if (mant == '0) begin
            s         <= sign_q;
            e         <= '0;
            m         <= '0;
            flag      <= FLAG_ZERO;
            oom       <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (mant[MW-1]) begin
            // Product in [2,4): one right shift, keep the dropped bit.
            mant   <= mant >> 1;
            sticky <= sticky | mant[0];
            exp_q  <= exp_q + EXP_ONE;
            state  <= ROUND;
          end else if (mant[MW-2]) begin
            state <= ROUND;
          end else begin
            mant  <= mant << 1;
            exp_q <= exp_q - EXP_ONE;
          end
        end

        ROUND: begin
          s         <= sign_q;
          flag      <= FLAG_FINITE;
          oom       <= out_of_range;
          e         <= out_of_range ? '0 : exp_rnd[EXP_W-1:0];
          m         <= out_of_range ? '0 : frac_sum[MAN_W-1:0];
          exp_q     <= exp_rnd;
          out_valid <= 1'b1;
          state     <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_norm_round.sv
// tb_norm_round: self-checking bench for norm_round. Expected results come
// from an arithmetic model of normalise + round-to-nearest-even working on
// integers (leading-one search, remainder vs half-ulp comparison).
module tb_norm_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_s;
  logic [9:0]  in_e;
  logic [47:0] in_m;
  logic [1:0]  in_flag;
  logic        out_valid;
  logic        out_ready;
  logic        s;
  logic [7:0]  e;
  logic [22:0] m;
  logic [1:0]  flag;
  logic        oom;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  norm_round dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_s      (in_s),
    .in_e      (in_e),
    .in_m      (in_m),
    .in_flag   (in_flag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .e         (e),
    .m         (m),
    .flag      (flag),
    .oom       (oom)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: value-level normalise and round-half-to-even.
  task automatic model(input logic s_i, input logic [9:0] e_i, input logic [47:0] m_i,
                       input logic [1:0] f_i, output logic x_s, output logic [7:0] x_e,
                       output logic [22:0] x_m, output logic [1:0] x_f, output logic x_oom,
                       output int lat);
    longint unsigned mant, keep, rem, half;
    int  ex, p, sh;
    bit  st, up;
    x_s = s_i; x_e = 0; x_m = 0; x_oom = 0;
    if (f_i != 2'b11) begin
      x_f = f_i; lat = 1;
    end else if (m_i == 48'd0) begin
      x_f = 2'b10; lat = 2;
    end else begin
      x_f = 2'b11;
      ex  = int'($signed(e_i));
      p   = 47;
      while (!m_i[p]) p--;
      st = 1'b0;
      if (p == 47) begin
        st = m_i[0]; mant = longint'(m_i) >> 1; ex = ex + 1; sh = 0;
      end else begin
        sh = 46 - p; mant = longint'(m_i) << sh; ex = ex - sh;
      end
      lat  = 3 + sh;
      keep = mant >> 23;                 // 1.fraction as a 24-bit integer
      rem  = mant % (64'd1 << 23);       // discarded bits
      half = 64'd1 << 22;
      up   = (rem > half) || (rem == half && (st || keep[0]));
      keep = keep + up;
      if (keep == (64'd1 << 24)) begin
        keep = 64'd1 << 23; ex = ex + 1;
      end
      if (ex > 254 || ex < 1) x_oom = 1'b1;
      else begin
        x_e = 8'(ex);
        x_m = 23'(keep % (64'd1 << 23));
      end
    end
  endtask

  // Drive one operand, check latency and result, hold DONE for `hold`
  // cycles, then release it with out_ready.
  task automatic run_op(input string tag, input logic s_i, input logic [9:0] e_i,
                        input logic [47:0] m_i, input logic [1:0] f_i, input int hold);
    logic x_s, x_oom;
    logic [7:0] x_e;
    logic [22:0] x_m;
    logic [1:0] x_f;
    int x_lat, lat;
    model(s_i, e_i, m_i, f_i, x_s, x_e, x_m, x_f, x_oom, x_lat);
    check({tag, ".in_ready"}, in_ready, 1);
    in_valid = 1'b1; in_s = s_i; in_e = e_i; in_m = m_i; in_flag = f_i;
    tick();
    in_valid = 1'b0; in_m = $urandom(); in_e = $urandom(); in_s = $urandom(); in_flag = $urandom();
    lat = 1;
    while (!out_valid && lat < 60) begin
      tick(); lat++;
    end
    check({tag, ".latency"}, lat, x_lat);
    check({tag, ".result"}, {s, e, m, flag, oom}, {x_s, x_e, x_m, x_f, x_oom});
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, ".hold"}, {out_valid, in_ready, s, e, m, flag, oom},
            {1'b1, 1'b0, x_s, x_e, x_m, x_f, x_oom});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".release"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic [47:0] rm, mask;
    int p;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_s = 1'b0; in_e = '0; in_m = '0; in_flag = 2'b00;
    tick(); tick();
    check("reset.outputs", {in_ready, out_valid, s, e, m, flag, oom}, '0);
    rst = 1'b1;
    #1;
    check("reset.in_ready", in_ready, 1);

    run_op("mul_1p5", 1'b0, 10'd127, 48'h9000_0000_0000, 2'b11, 0);
    run_op("lead44",  1'b0, 10'd130, 48'h1000_0000_0000, 2'b11, 0);
    run_op("carry",   1'b1, 10'd100, 48'h7FFF_FFC0_0000, 2'b11, 0);
    run_op("tie_even", 1'b0, 10'd90, 48'h4000_0040_0000, 2'b11, 0);
    run_op("sticky_up", 1'b0, 10'd90, 48'h8000_0080_0001, 2'b11, 0);
    run_op("overflow", 1'b0, 10'd254, 48'h8000_0000_0000, 2'b11, 0);
    run_op("underflow", 1'b1, 10'd1, 48'h2000_0000_0000, 2'b11, 0);
    run_op("inf",     1'b1, 10'd77, 48'h1234_5678_9ABC, 2'b00, 0);
    run_op("invalid", 1'b0, 10'd3, 48'h8000_0000_0000, 2'b01, 0);
    run_op("zero_m",  1'b1, 10'd50, 48'h0, 2'b11, 0);
    run_op("hold4",   1'b0, 10'd127, 48'h4800_0000_0000, 2'b11, 4);
    run_op("max_shift", 1'b0, 10'd200, 48'h1, 2'b11, 0);

    // Reset while normalising a long-shift operand.
    in_valid = 1'b1; in_s = 1'b1; in_e = 10'd120; in_m = 48'h0000_0000_0003; in_flag = 2'b11;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    #1;
    check("midrst.held", {out_valid, in_ready, s, e, m, flag, oom}, '0);
    tick();
    check("midrst.still", {out_valid, in_ready}, 2'b00);
    #2;
    rst = 1'b1;
    #1;
    check("midrst.ready", {out_valid, in_ready}, 2'b01);
    run_op("after_rst", 1'b1, 10'd127, 48'h9000_0000_0000, 2'b11, 1);

    // Randomised operands against the model.
    for (int n = 0; n < 60; n++) begin
      p  = $urandom_range(0, 47);
      rm = {$urandom(), $urandom()};
      mask = (48'd1 << p) - 48'd1;
      rm = (48'd1 << p) | (rm & mask);
      if ($urandom_range(0, 7) == 0) rm = rm & ~48'h3F_FFFF | 48'h40_0000; // force ties
      run_op("random", 1'($urandom()), 10'($urandom_range(0, 275) - 20), rm,
             ($urandom_range(0, 7) == 0) ? 2'($urandom()) : 2'b11, $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/norm_round.md
Name: norm_round

Overview:
- Sequential normalise-and-round stage of the single-precision FPU datapath.
- Takes the raw sign, exponent and double-width mantissa from the multiply/add core. Normalises the mantissa iteratively (one shift per cycle) and applies IEEE round-to-nearest-even.
- Drives the s/e/m/flag/oom fields consumed by the result-packing stage, under a valid/ready handshake on both sides.

Parameters:
- EXP_W, 8, output exponent width; internal/input exponent is EXP_W+2 bits signed.
- MAN_W, 23, output fraction width; input mantissa is 2*MAN_W+2 = 48 bits, binary point between bits 46 and 45.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream operand valid
- in_ready  out  1  stage can accept (high only in IDLE, low while rst asserted)
- in_s  in  1  result sign
- in_e  in  10  biased exponent, two's complement signed
- in_m  in  48  unnormalised mantissa
- in_flag  in  2  class: 00 infinity, 01 invalid, 10 zero, 11 finite
- out_valid  out  1  s/e/m/flag/oom valid
- out_ready  in  1  downstream accepts
- s  out  1  sign
- e  out  8  biased exponent
- m  out  23  fraction
- flag  out  2  class to packing stage
- oom  out  1  exponent out of range (overflow or underflow)

Behaviour:
- Reset (rst low, async):
  - state=IDLE; out_valid=0; s=0, e=0, m=0, flag=00, oom=0; internal regs cleared.
  - Reset mid-operation abandons the operation with no output.
- FSM states: IDLE, NORM, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_s, in_e, in_m, in_flag; clear sticky.
  - If in_flag!=11, go to DONE with s=in_s, e=0, m=0, flag=in_flag, oom=0. Latency 1: out_valid in the cycle after acceptance.
  - Otherwise go to NORM.
- NORM (one action per cycle, evaluated in this priority order):
  - mant==0: flag=10, e=0, m=0, oom=0, go to DONE.
  - mant[47]=1: mant>>=1, sticky|=mant[0], exp+=1, go to ROUND.
  - mant[46]=1: go to ROUND.
  - Otherwise: mant<<=1, exp-=1, stay in NORM.
  - A nonzero mantissa always terminates within 46 shifts.
- ROUND (single cycle):
  - lsb=mant[23], guard=mant[22], st=|mant[21:0] | sticky.
  - inc = guard & (st | lsb).
  - r = {1,mant[45:23]} + inc (25-bit). If r[24]=1: frac=0, exp+=1. Otherwise frac=r[22:0].
  - If exp>254 or exp<1 (signed): oom=1, e=0, m=0. Otherwise oom=0, e=exp[7:0], m=frac.
  - flag=11. Go to DONE.
- DONE:
  - out_valid=1; all outputs held stable; in_ready=0.
  - On out_ready: out_valid drops the next cycle and state returns to IDLE.
  - A new operand is not accepted in the same cycle as out_ready (no overlap).
- Latency from acceptance to out_valid:
  - Leading one at bit 47 or 46: 3 cycles.
  - Each extra left shift adds 1 cycle.
  - Special classes: 1 cycle.
- Exponent arithmetic is 10-bit signed throughout; no wrap is possible for in_e in [-256,255] with at most 47 shifts.
- No subnormal outputs; underflow is reported via oom.

Test Plan:
- 1.5*1.5: in_e=127, in_m=0x900000000000, in_flag=11 -> out_valid at cycle 3; e=128, m=0x100000, flag=11, oom=0.
- Leading one at bit 44: in_m=0x100000000000, in_e=130 -> two NORM shifts, out_valid at cycle 5; e=128, m=0.
- Rounding:
  - Carry: in_m=0x7FFFFFC00000, in_e=100 -> increment carries out; e=101, m=0.
  - Tie-to-even: in_m=0x400000400000 -> no increment; m=0, e=in_e.
- Range:
  - Overflow: in_e=254, in_m bit47 set -> oom=1, e=0, m=0, flag=11.
  - Underflow: in_e=1, in_m=0x200000000000 -> exp=0 -> oom=1.
- Specials and zero:
  - in_flag=00, in_s=1 -> out_valid next cycle; s=1, flag=00, e=0, m=0, oom=0.
  - in_flag=11 with in_m=0 -> flag=10.
- Handshake and reset:
  - out_ready held low 4 cycles in DONE -> outputs stable, in_ready=0; accepted on the cycle out_ready rises.
  - rst pulsed low while in NORM -> out_valid=0 immediately; in_ready=1 after release; next operand is processed correctly.
